inst_fetch_cache: RTL and testbench
===================================

INST_FETCH_CACHE -- requirements
Module: inst_fetch_cache

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32: width of one instruction word and of all addresses.
REQ-002 SHALL have parameter BLOCK_SIZE, default 4: words per block, power of two, equal to the instruction memory block size.
REQ-003 SHALL have parameter NUM_LINES, default 4: direct-mapped cache lines, power of two.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port pc, input, WORD_SIZE: word address of the requested instruction.
REQ-007 SHALL have port pc_valid, input, 1: fetch request this cycle.
REQ-008 SHALL have port inst_out, output, WORD_SIZE: fetched instruction, registered.
REQ-009 SHALL have port inst_valid, output, 1: inst_out holds a new instruction this cycle.
REQ-010 SHALL have port stall, output, 1: request not accepted; requester holds pc and pc_valid.
REQ-011 SHALL have port mem_req, output, 1: block fill request to the instruction memory.
REQ-012 SHALL have port mem_addr, output, WORD_SIZE: block base word address (offset bits zero).
REQ-013 SHALL have port mem_block, input, WORD_SIZE*BLOCK_SIZE: block from memory; word i at bits [i*WORD_SIZE +: WORD_SIZE].
REQ-014 SHALL have port mem_ready, input, 1: mem_block valid this cycle; fill completes.
REQ-015 SHALL have port miss_count, output, 16: number of completed fills, saturating at 0xFFFF.

Function
REQ-016 SHALL split pc into offset = pc[log2(BLOCK_SIZE)-1:0], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
REQ-017 SHALL hold one valid bit, one tag and one BLOCK_SIZE-word data block per line.
REQ-018 SHALL implement FSM states IDLE and FILL.
REQ-019 SHALL in IDLE treat pc_valid with a valid line and matching tag as a hit: stall=0; on the next rising edge, inst_out = word[offset] and inst_valid=1.
REQ-020 SHALL in IDLE treat pc_valid without a hit as a miss: stall=1 combinationally in the same cycle; latch the block base address; next state FILL.
REQ-021 SHALL in FILL drive mem_req=1 and mem_addr = the latched base address, and hold both stable until mem_ready.
REQ-022 SHALL on mem_ready in FILL write mem_block, the tag and valid=1 into the indexed line, increment miss_count, and return to IDLE; the held pc then hits one cycle later.
REQ-023 SHALL keep stall=1 for every cycle spent in FILL, regardless of pc_valid.
REQ-024 SHALL ignore pc changes during FILL; the fill uses only the latched address.
REQ-025 SHALL ignore mem_ready in IDLE.
REQ-026 SHALL drive inst_valid=0 in any cycle that follows a cycle without a hit; inst_out SHALL then hold its previous value.
REQ-027 SHALL, on a conflict miss (valid line, different tag), overwrite the line; there is no other replacement state.
REQ-028 SHALL keep pc_valid=0 in IDLE as a no-op: stall=0 and no state change.

Reset
REQ-029 SHALL on rst=1 immediately clear all valid bits, FSM to IDLE, mem_req=0, mem_addr=0, inst_out=0, inst_valid=0 and miss_count=0; stall SHALL then follow REQ-020 and REQ-028.
REQ-030 SHALL abandon any fill in progress on rst, without writing the line; mem_ready arriving after reset is ignored.

Verification
REQ-031 SHALL verify reset: assert rst mid-simulation -> all outputs zero and valid bits cleared without waiting for a clock edge.
REQ-032 SHALL verify cold miss: pc=1, pc_valid=1 -> stall=1, mem_req=1, mem_addr=0; mem_ready after 3 cycles with block {w3,w2,w1,w0} -> next cycle inst_out=w1, inst_valid=1, miss_count=1.
REQ-033 SHALL verify hit latency: pc=2 after REQ-032 -> stall=0, no mem_req, next cycle inst_out=w2, inst_valid=1.
REQ-034 SHALL verify conflict: pc=35 (offset 3, index 0, tag 2) -> miss with mem_addr=32; after the fill, inst_out = word 3 of the new block; then pc=1 misses again with mem_addr=0 and miss_count=3.
REQ-035 SHALL verify reset mid-fill: rst during FILL with mem_ready later pulsed -> mem_req=0, line 0 stays invalid, miss_count=0, and the next pc=1 misses.
REQ-036 SHALL verify pc changes during FILL: pc toggled 1 to 35 while filling -> mem_addr stays 0 until mem_ready.

Source files
------------

// File: rtl/inst_fetch_cache_if.sv
// Fetch-side and memory-side signals of the instruction fetch cache.
// The slave modport is the cache's view; the master modport is the requester/memory side.
interface inst_fetch_cache_if #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 4
);
  logic [WORD_SIZE-1:0]            pc;
  logic                            pc_valid;
  logic [WORD_SIZE-1:0]            inst_out;
  logic                            inst_valid;
  logic                            stall;
  logic                            mem_req;
  logic [WORD_SIZE-1:0]            mem_addr;
  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_block;
  logic                            mem_ready;
  logic [15:0]                     miss_count;

  modport slave (
    input  pc, pc_valid, mem_block, mem_ready,
    output inst_out, inst_valid, stall, mem_req, mem_addr, miss_count
  );

  modport master (
    output pc, pc_valid, mem_block, mem_ready,
    input  inst_out, inst_valid, stall, mem_req, mem_addr, miss_count
  );
endinterface

// File: rtl/inst_fetch_cache.sv
// Direct-mapped instruction cache with whole-block refill from instruction memory.
// state | meaning
// IDLE  | serve hits; a miss latches the block base address and moves to FILL
// FILL  | mem_req held with the latched address until mem_ready writes the line
module inst_fetch_cache #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int NUM_LINES  = 4
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_cache_if.slave bus
);
  localparam int OFF_W = $clog2(BLOCK_SIZE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                               state_q, state_d;
  logic [NUM_LINES-1:0]                 valid_q, valid_d;
  logic [TAG_W-1:0]                     tag_q  [NUM_LINES];
  logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0] data_q [NUM_LINES];
  logic                                 mem_req_q, mem_req_d;
  logic [WORD_SIZE-1:0]                 mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]                 inst_out_q, inst_out_d;
  logic                                 inst_valid_q, inst_valid_d;
  logic [15:0]                          miss_count_q, miss_count_d;

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx, fill_idx;
  logic [TAG_W-1:0] pc_tag, fill_tag;
  logic             hit, fill_done;

  assign pc_off   = bus.pc[OFF_W-1:0];
  assign pc_idx   = bus.pc[OFF_W +: IDX_W];
  assign pc_tag   = bus.pc[WORD_SIZE-1:OFF_W+IDX_W];
  // The line being filled is addressed only through the latched base address.
  assign fill_idx = mem_addr_q[OFF_W +: IDX_W];
  assign fill_tag = mem_addr_q[WORD_SIZE-1:OFF_W+IDX_W];

  assign hit       = (state_q == IDLE) && bus.pc_valid && valid_q[pc_idx] &&
                     (tag_q[pc_idx] == pc_tag);
  assign fill_done = (state_q == FILL) && bus.mem_ready;

  assign bus.stall      = (state_q == FILL) || (bus.pc_valid && !hit);
  assign bus.inst_out   = inst_out_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.miss_count = miss_count_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    inst_out_d   = inst_out_q;
    inst_valid_d = hit;
    miss_count_d = miss_count_q;
    if (hit) inst_out_d = data_q[pc_idx][pc_off];
    case (state_q)
      IDLE: begin
        if (bus.pc_valid && !hit) begin
          state_d    = FILL;
          mem_req_d  = 1'b1;
          mem_addr_d = {bus.pc[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
        end
      end
      FILL: begin
        if (bus.mem_ready) begin
          state_d           = IDLE;
          mem_req_d         = 1'b0;
          valid_d[fill_idx] = 1'b1;
          if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      inst_out_q   <= '0;
      inst_valid_q <= 1'b0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      inst_out_q   <= inst_out_d;
      inst_valid_q <= inst_valid_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data storage need no reset: the valid bits guard every read.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_block;
    end
  end
endmodule

// File: tb/tb_inst_fetch_cache.sv
// Scoreboard bench for inst_fetch_cache: a tag model predicts hit/miss, expected
// instructions are queued on accepted requests and popped when inst_valid appears.
module tb_inst_fetch_cache;
  logic clk;
  logic rst;

  inst_fetch_cache_if #(.WORD_SIZE(32), .BLOCK_SIZE(4)) bus ();

  inst_fetch_cache #(.WORD_SIZE(32), .BLOCK_SIZE(4), .NUM_LINES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic        m_valid [4];
  logic [27:0] m_tag   [4];
  logic [15:0] m_count;
  logic [31:0] last_inst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [127:0] mem_blk(input logic [31:0] base);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = mem_word(base + 32'(i));
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_count = '0;
  endtask

  always @(negedge clk) begin
    if (bus.inst_valid === 1'b1) begin
      if (sb.size() == 0) chk("spurious_inst_valid", 32'(bus.inst_valid), 32'd0);
      else chk("inst_out", bus.inst_out, sb.pop_front());
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_inst_out", bus.inst_out, 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_miss_count", 32'(bus.miss_count), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
  endtask

  // One fetch; on a predicted miss the fill is answered after dly FILL cycles.
  task automatic access(input logic [31:0] a, input int dly, input bit toggle);
    logic [31:0] base;
    int          idx;
    bit          miss;
    base = {a[31:2], 2'b00};
    idx  = int'(a[3:2]);
    miss = !(m_valid[idx] && m_tag[idx] == a[31:4]);
    bus.pc       = a;
    bus.pc_valid = 1'b1;
    #1;
    chk("stall_on_req", 32'(bus.stall), 32'(miss));
    if (bus.stall) begin
      @(posedge clk); #1;
      for (int i = 0; i < dly; i++) begin
        chk("fill_mem_req", 32'(bus.mem_req), 32'd1);
        chk("fill_mem_addr", bus.mem_addr, base);
        chk("fill_stall", 32'(bus.stall), 32'd1);
        if (toggle) bus.pc = (i % 2 == 0) ? (a ^ 32'h22) : a;
        @(posedge clk); #1;
      end
      chk("fill_mem_addr_at_ready", bus.mem_addr, base);
      bus.pc        = a;
      bus.mem_block = mem_blk(base);
      bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[31:4];
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      #1;
      chk("refill_hit_stall", 32'(bus.stall), 32'd0);
      chk("post_fill_mem_req", 32'(bus.mem_req), 32'd0);
    end
    chk("miss_count", 32'(bus.miss_count), 32'(m_count));
    if (!bus.stall) sb.push_back(mem_word(a));
    last_inst = mem_word(a);
    @(posedge clk); #1;
    bus.pc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.pc        = '0;
    bus.pc_valid  = 1'b0;
    bus.mem_block = '0;
    bus.mem_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_noop_stall", 32'(bus.stall), 32'd0);

    access(32'd1, 3, 1'b0);
    access(32'd2, 0, 1'b0);
    @(posedge clk); #1;
    chk("idle_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("idle_inst_out_hold", bus.inst_out, last_inst);

    access(32'd35, 2, 1'b0);
    access(32'd1, 1, 1'b0);
    chk("conflict_miss_count", 32'(bus.miss_count), 32'd3);

    bus.mem_block = mem_blk(32'd40);
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    chk("idle_mem_ready_ignored", 32'(bus.miss_count), 32'(m_count));
    chk("idle_mem_ready_no_req", 32'(bus.mem_req), 32'd0);

    for (int k = 0; k < 12; k++) access(32'($urandom_range(0, 63)), int'($urandom_range(0, 3)), 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Abort a fill of line 0 with an asynchronous reset.
    bus.pc       = 32'd35;
    bus.pc_valid = 1'b1;
    #1;
    chk("abort_req_stall", 32'(bus.stall), 32'(!(m_valid[0] && m_tag[0] == 28'd2)));
    @(posedge clk); #1;
    chk("abort_fill_mem_req", 32'(bus.mem_req), 32'd1);
    @(posedge clk); #1;
    bus.pc_valid = 1'b0;
    rst          = 1'b1;
    #1;
    chk_reset_outputs();
    model_clear();
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.mem_block = mem_blk(32'd32);
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    chk("abort_mem_req", 32'(bus.mem_req), 32'd0);
    chk("abort_miss_count", 32'(bus.miss_count), 32'd0);

    access(32'd1, 4, 1'b1);
    access(32'd3, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
